// File: rtl/trail_pkg.sv
// Shared types and default widths for the solver trail / VDE event driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trail_pkg;

    localparam int TRAIL_MAX_VARS = 256;
    localparam int TRAIL_VAR_W    = 32;
    localparam int TRAIL_LVL_W    = 16;

    // One trail entry: the assigned variable, its polarity and its decision level.
    typedef struct packed {
        logic [TRAIL_VAR_W-1:0] var_id;
        logic                   val;
        logic [TRAIL_LVL_W-1:0] level;
    } trail_entry_t;

    // Driver FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_UNWIND = 2'd1;
    localparam state_t S_DONE   = 2'd2;

endpackage

// File: rtl/trail_lifo.sv
// Trail storage: LIFO of trail entries with a combinational view of the top entry.
// Latency: push/pop take effect on the next edge; top_entry follows count with no delay.
// Backpressure: none; the caller must not push when full or pop when empty.
module trail_lifo
    import trail_pkg::*;
#(
    parameter int DEPTH = TRAIL_MAX_VARS,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  trail_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output trail_entry_t       top_entry
);

    trail_entry_t       mem [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;

    assign wr_idx  = IDX_W'(count_q);
    assign top_idx = IDX_W'(count_q - CNT_W'(1));

    // Next occupancy: flush beats push beats pop.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care below count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_idx] <= push_entry;
        end
    end

    assign count     = count_q;
    assign top_entry = (count_q == '0) ? '0 : mem[top_idx];

endmodule

// File: rtl/trail_vde_driver.sv
// Solver trail keeper that feeds assign / clear / unassign_all events to the VDE.
// Latency: assign 1 cycle after push; clears start 2 cycles after bt_req, one per cycle.
// Backpressure: push_ready drops while unwinding, on bt_req/restart, or when the trail is full.
module trail_vde_driver
    import trail_pkg::*;
#(
    parameter int MAX_VARS = TRAIL_MAX_VARS,
    parameter int VAR_W    = TRAIL_VAR_W,
    parameter int LVL_W    = TRAIL_LVL_W,
    localparam int CNT_W   = $clog2(MAX_VARS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [VAR_W-1:0]   push_var,
    input  logic               push_value,
    input  logic [LVL_W-1:0]   push_level,
    input  logic               bt_req,
    input  logic [LVL_W-1:0]   bt_level,
    output logic               bt_busy,
    output logic               bt_done,
    input  logic               restart,
    output logic               assign_valid,
    output logic [VAR_W-1:0]   assign_var,
    output logic               assign_value,
    output logic               clear_valid,
    output logic [VAR_W-1:0]   clear_var,
    output logic               unassign_all,
    output logic [CNT_W-1:0]   trail_count,
    output logic [LVL_W-1:0]   top_level,
    output logic               overflow
);

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   bt_lvl_q, bt_lvl_d;
    logic               overflow_q, overflow_d;
    logic               assign_valid_q, assign_valid_d;
    logic [VAR_W-1:0]   assign_var_q, assign_var_d;
    logic               assign_value_q, assign_value_d;
    logic               clear_valid_q, clear_valid_d;
    logic [VAR_W-1:0]   clear_var_q, clear_var_d;
    logic               unassign_all_q, unassign_all_d;

    logic               lifo_push, lifo_pop, lifo_flush;
    logic [CNT_W-1:0]   count;
    trail_entry_t       push_entry;
    trail_entry_t       top_entry;
    logic               full;

    assign push_entry = '{var_id: push_var, val: push_value, level: push_level};
    assign full       = (count == CNT_W'(MAX_VARS));

    trail_lifo #(
        .DEPTH      (MAX_VARS)
    ) u_lifo (
        .clk        (clk),
        .rst        (reset),
        .push       (lifo_push),
        .push_entry (push_entry),
        .pop        (lifo_pop),
        .flush      (lifo_flush),
        .count      (count),
        .top_entry  (top_entry)
    );

    assign push_ready = (state_q == S_IDLE) && !bt_req && !restart && !full;

    // FSM, trail control and next VDE event; restart overrides everything else.
    always_comb begin
        state_d        = state_q;
        bt_lvl_d       = bt_lvl_q;
        overflow_d     = overflow_q;
        lifo_push      = 1'b0;
        lifo_pop       = 1'b0;
        lifo_flush     = 1'b0;
        assign_valid_d = 1'b0;
        assign_var_d   = '0;
        assign_value_d = 1'b0;
        clear_valid_d  = 1'b0;
        clear_var_d    = '0;
        unassign_all_d = 1'b0;
        if (restart) begin
            lifo_flush     = 1'b1;
            overflow_d     = 1'b0;
            state_d        = S_IDLE;
            unassign_all_d = 1'b1;
        end else begin
            if (push_valid && full) begin
                overflow_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bt_req) begin
                        bt_lvl_d = bt_level;
                        state_d  = S_UNWIND;
                    end else if (push_valid && push_ready) begin
                        lifo_push      = 1'b1;
                        assign_valid_d = 1'b1;
                        assign_var_d   = push_var;
                        assign_value_d = push_value;
                    end
                end
                S_UNWIND: begin
                    if ((count != '0) && (top_entry.level > bt_lvl_q)) begin
                        lifo_pop      = 1'b1;
                        clear_valid_d = 1'b1;
                        clear_var_d   = top_entry.var_id;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, latched backtrack level, sticky overflow and registered VDE outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bt_lvl_q       <= '0;
            overflow_q     <= 1'b0;
            assign_valid_q <= 1'b0;
            assign_var_q   <= '0;
            assign_value_q <= 1'b0;
            clear_valid_q  <= 1'b0;
            clear_var_q    <= '0;
            unassign_all_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bt_lvl_q       <= bt_lvl_d;
            overflow_q     <= overflow_d;
            assign_valid_q <= assign_valid_d;
            assign_var_q   <= assign_var_d;
            assign_value_q <= assign_value_d;
            clear_valid_q  <= clear_valid_d;
            clear_var_q    <= clear_var_d;
            unassign_all_q <= unassign_all_d;
        end
    end

    assign bt_busy      = (state_q != S_IDLE);
    assign bt_done      = (state_q == S_DONE);
    assign assign_valid = assign_valid_q;
    assign assign_var   = assign_var_q;
    assign assign_value = assign_value_q;
    assign clear_valid  = clear_valid_q;
    assign clear_var    = clear_var_q;
    assign unassign_all = unassign_all_q;
    assign trail_count  = count;
    assign top_level    = top_entry.level;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_trail_vde_driver.sv
// Testbench for trail_vde_driver with a small trail so overflow is reachable.
// Reference model: a queue of entries plus a time schedule of expected events per backtrack.
// Outputs are compared every cycle at the falling edge.
module tb_trail_vde_driver;
    import trail_pkg::*;

    localparam int MAXV = 4;
    localparam int CW   = $clog2(MAXV + 1);

    logic           clk;
    logic           reset;
    logic           push_valid;
    logic           push_ready;
    logic [31:0]    push_var;
    logic           push_value;
    logic [15:0]    push_level;
    logic           bt_req;
    logic [15:0]    bt_level;
    logic           bt_busy;
    logic           bt_done;
    logic           restart;
    logic           assign_valid;
    logic [31:0]    assign_var;
    logic           assign_value;
    logic           clear_valid;
    logic [31:0]    clear_var;
    logic           unassign_all;
    logic [CW-1:0]  trail_count;
    logic [15:0]    top_level;
    logic           overflow;

    trail_vde_driver #(.MAX_VARS(MAXV)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_var     (push_var),
        .push_value   (push_value),
        .push_level   (push_level),
        .bt_req       (bt_req),
        .bt_level     (bt_level),
        .bt_busy      (bt_busy),
        .bt_done      (bt_done),
        .restart      (restart),
        .assign_valid (assign_valid),
        .assign_var   (assign_var),
        .assign_value (assign_value),
        .clear_valid  (clear_valid),
        .clear_var    (clear_var),
        .unassign_all (unassign_all),
        .trail_count  (trail_count),
        .top_level    (top_level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    trail_entry_t m_q[$];
    bit           m_ovf;
    bit           bt_active;
    int           bt_edge;
    int           bt_k;
    int           edge_n;
    bit           e_av, e_aval, e_cv, e_ua, e_done;
    logic [31:0]  e_avar, e_cvar;
    int           clears_seen;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; bt_active = 0; bt_edge = 0; bt_k = 0; edge_n = 0;
        e_av = 0; e_aval = 0; e_cv = 0; e_ua = 0; e_done = 0;
        e_avar = '0; e_cvar = '0;
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = !bt_active && !bt_req && !restart && (m_q.size() < MAXV);
        chk("push_ready", push_ready, exp_rdy);
        chk("assign_valid", assign_valid, e_av);
        if (e_av) begin
            chk("assign_var", assign_var, e_avar);
            chk("assign_value", assign_value, e_aval);
        end
        chk("clear_valid", clear_valid, e_cv);
        if (e_cv) chk("clear_var", clear_var, e_cvar);
        chk("unassign_all", unassign_all, e_ua);
        chk("bt_done", bt_done, e_done);
        chk("bt_busy", bt_busy, bt_active);
        chk("trail_count", trail_count, m_q.size());
        chk("top_level", top_level, (m_q.size() > 0) ? m_q[m_q.size()-1].level : 16'd0);
        chk("overflow", overflow, m_ovf);
        if (clear_valid) clears_seen++;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        int rel;
        trail_entry_t e;
        edge_n++;
        e_av = 0; e_cv = 0; e_ua = 0; e_done = 0;
        if (restart) begin
            m_q.delete();
            m_ovf = 0;
            bt_active = 0;
            e_ua = 1;
        end else begin
            if (push_valid && m_q.size() == MAXV) m_ovf = 1;
            if (!bt_active) begin
                if (bt_req) begin
                    bt_active = 1;
                    bt_edge = edge_n;
                    bt_k = 0;
                    for (int i = m_q.size() - 1; i >= 0; i--) begin
                        if (m_q[i].level > bt_level) bt_k++;
                        else break;
                    end
                end else if (push_valid && m_q.size() < MAXV) begin
                    e.var_id = push_var; e.val = push_value; e.level = push_level;
                    m_q.push_back(e);
                    e_av = 1; e_avar = push_var; e_aval = push_value;
                end
            end else begin
                rel = edge_n - bt_edge;
                if (rel >= 1 && rel <= bt_k) begin
                    e = m_q.pop_back();
                    e_cv = 1; e_cvar = e.var_id;
                end else if (rel == bt_k + 1) begin
                    e_done = 1;
                end else begin
                    bt_active = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic pv, input logic [31:0] v, input logic val,
                       input logic [15:0] lvl, input logic bt, input logic [15:0] btl,
                       input logic rs);
        push_valid = pv; push_var = v; push_value = val; push_level = lvl;
        bt_req = bt; bt_level = btl; restart = rs;
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] v, input logic val, input logic [15:0] lvl);
        cyc(1, v, val, lvl, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        push_valid = 0; push_var = 0; push_value = 0; push_level = 0;
        bt_req = 0; bt_level = 0; restart = 0;
        clears_seen = 0;
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three pushes, assign events one cycle behind each.
        push(5, 1, 1);
        push(9, 0, 1);
        push(12, 1, 2);
        idle(1);
        chk("tp1_count", trail_count, 3);
        chk("tp1_top_level", top_level, 2);

        // Full unwind to level 0: clears for 12, 9, 5.
        clears_seen = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(5);
        chk("tp2_clears", clears_seen, 3);
        chk("tp2_count", trail_count, 0);

        // Levels {1,2,2,3}, keep level <= 1.
        push(20, 1, 1);
        push(21, 0, 2);
        push(22, 1, 2);
        push(23, 0, 3);
        clears_seen = 0;
        cyc(0, 0, 0, 0, 1, 1, 0);
        idle(6);
        chk("tp3_clears", clears_seen, 3);
        chk("tp3_top_level", top_level, 1);

        // bt_level above the top level: nothing to pop.
        push(30, 1, 2);
        push(31, 1, 3);
        idle(1);
        clears_seen = 0;
        cyc(0, 0, 0, 0, 1, 5, 0);
        idle(4);
        chk("tp4_clears", clears_seen, 0);
        chk("tp4_count", trail_count, 3);

        // Restart after the first clear of an unwind.
        clears_seen = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(4);
        chk("tp5_clears", clears_seen, 1);
        chk("tp5_count", trail_count, 0);
        chk("tp5_push_ready", push_ready, 1);

        // Fill the trail, then one push too many.
        push(40, 1, 1);
        push(41, 0, 1);
        push(42, 1, 2);
        push(43, 0, 2);
        push(44, 1, 3);
        idle(1);
        chk("tp6_overflow", overflow, 1);
        chk("tp6_count", trail_count, MAXV);

        // Asynchronous reset mid-cycle.
        push_valid = 0; bt_req = 0; restart = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
                16'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/trail_vde_driver.md
Name: trail_vde_driver

Overview:
- Source side of the VDE assignment/clear event interface.
- Keeps the solver trail: a LIFO of assigned variables, each tagged with its decision level.
- Forwards every new assignment to the VDE as one assign event.
- On backtrack, pops the trail and issues one clear event per cycle for every entry above the target level; on restart, empties the trail and issues unassign_all.

Parameters:
- MAX_VARS, 256, trail depth; one entry per variable.
- VAR_W, 32, width of a variable id; matches the VDE var ports.
- LVL_W, 16, width of a decision level.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- push_valid  in  1  append trail entry
- push_ready  out  1  push accepted this cycle
- push_var  in  VAR_W  variable id
- push_value  in  1  assigned polarity
- push_level  in  LVL_W  decision level of the entry
- bt_req  in  1  backtrack request (single-cycle pulse)
- bt_level  in  LVL_W  keep entries with level <= bt_level
- bt_busy  out  1  unwind in progress
- bt_done  out  1  one-cycle pulse when unwind completes
- restart  in  1  drop entire trail
- assign_valid  out  1  to VDE
- assign_var  out  VAR_W  to VDE
- assign_value  out  1  to VDE
- clear_valid  out  1  to VDE
- clear_var  out  VAR_W  to VDE
- unassign_all  out  1  to VDE, one-cycle pulse
- trail_count  out  $clog2(MAX_VARS+1)  current number of entries
- top_level  out  LVL_W  level of the top entry; 0 when the trail is empty
- overflow  out  1  sticky: a push was attempted while the trail was full

Behaviour:
- Reset values:
  - All outputs 0, except push_ready = 1.
  - FSM in S_IDLE; trail_count = 0; overflow = 0.
- All VDE-side outputs are registered.
- At most one of assign_valid / clear_valid / unassign_all is high in any cycle, because the VDE FIFO takes one event per cycle.
- push_ready is combinational and equals (state == S_IDLE && !bt_req && !restart && trail_count < MAX_VARS).
- Push, in S_IDLE, when push_valid && push_ready:
  - Write {var, value, level} at index trail_count; trail_count increments.
  - Next cycle: assign_valid = 1 with that var and value (latency 1).
- push_valid while trail_count == MAX_VARS: overflow is set (sticky until reset or restart); the entry is dropped.
- bt_req in S_IDLE: latch bt_level and go to S_UNWIND. bt_req outside S_IDLE is ignored.
- S_UNWIND, evaluated each cycle:
  - If trail_count > 0 and the top entry's level > the latched level: pop the entry, trail_count decrements, and clear_valid/clear_var show it on the next cycle.
  - Otherwise go to S_DONE.
  - Throughput is one clear per cycle. Pops are strictly LIFO (the most recently assigned variable is cleared first).
- S_DONE: bt_done pulses for 1 cycle, then the FSM returns to S_IDLE.
  - bt_busy = (state != S_IDLE).
  - Minimum bt_req-to-bt_done latency is 2 cycles; this case (zero pops) occurs when the trail is empty or bt_level >= top_level.
- restart in any state:
  - Takes priority over bt_req and push.
  - trail_count <= 0; overflow <= 0; FSM goes to S_IDLE.
  - Next cycle: unassign_all = 1 and no clear events are issued.
  - An unwind in progress is aborted without a bt_done pulse.
- Simultaneous events:
  - bt_req together with push_valid in S_IDLE: the backtrack wins; push_ready = 0, so the push is not taken.
  - An assign registered in the previous cycle is still emitted even if an unwind starts; clears begin one cycle later, so no overlap occurs.
- Asynchronous reset at any point returns the block to the reset state immediately. Trail memory contents need not be cleared.
- top_level is read combinationally from entry trail_count-1 (0 if the trail is empty).
- Levels compare as unsigned.

Decomposition:
- Package trail_pkg:
  - trail_entry_t, a packed struct {var_id, val, level}.
  - State enum {S_IDLE, S_UNWIND, S_DONE}.
  - Default widths.
- One sub-module, trail_lifo:
  - Array of trail_entry_t, write port at count, combinational read of the top entry.
  - push/pop/flush inputs and a count output.

Test Plan:
- Push vars 5(+, L1), 9(-, L1), 12(+, L2) -> assign events 5/1, 9/0, 12/1 on consecutive cycles, each 1 cycle after its push; trail_count = 3; top_level = 2.
- Then bt_req with bt_level = 0 -> clears for 12, 9, 5 on 3 consecutive cycles; bt_done 1 cycle after the last clear; trail_count = 0.
- Trail with levels {1, 2, 2, 3}, bt_level = 1 -> exactly 3 clears (the L3 entry then the two L2 entries); top_level = 1 afterwards.
- bt_req with bt_level = 5 while top_level = 3 -> no clear_valid; bt_done 2 cycles after bt_req.
- restart during an unwind after 1 clear -> unassign_all pulses once; no further clears; no bt_done; trail_count = 0; push_ready = 1.
- Fill MAX_VARS = 4 with 4 pushes, then push a 5th -> push_ready = 0, overflow = 1, no assign event; assert reset -> all outputs at reset values.
